html_writer: RTL and testbench
==============================

HTML_WRITER -- requirements
Module: html_writer

Interface
REQ-001 SHALL have parameter DEPTH, default 16; FIFO entries, power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, default 16; width of char_count.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port state_enable  input  1  reset, asynchronous, active-low (0 = reset, 1 = run).
REQ-005 SHALL have port in_valid  input  1  producer presents in_char.
REQ-006 SHALL have port in_char  input  8  character from producer.
REQ-007 SHALL have port in_last  input  1  qualifies in_char as final character of the document.
REQ-008 SHALL have port in_ready  output  1  writer accepts in_char this cycle.
REQ-009 SHALL have port out_char  output  8  character stream to sink.
REQ-010 SHALL have port out_valid  output  1  out_char holds a valid character.
REQ-011 SHALL have port out_ready  input  1  sink accepts out_char.
REQ-012 SHALL have port has_finished  output  1  whole document emitted.
REQ-013 SHALL have port char_count  output  CNT_W  characters emitted since reset.

Function
REQ-014 Input transfer SHALL occur on a rising edge with in_valid=1 and in_ready=1; output transfer with out_valid=1 and out_ready=1.
REQ-015 FSM SHALL have states IDLE (no char yet), STREAM, DRAIN (last accepted, FIFO not empty), DONE.
REQ-016 Transitions: IDLE->STREAM on first input transfer; STREAM->DRAIN on input transfer with in_last=1; DRAIN->DONE on the output transfer that empties FIFO and output stage; IDLE/STREAM->DONE directly if last char enters and leaves in the same path with no backlog.
REQ-017 in_ready SHALL be 1 only in IDLE/STREAM with FIFO not full; full is registered, so no push when full even if a pop happens the same cycle.
REQ-018 Minimum latency: char accepted at edge N SHALL appear on out_valid after edge N+1 when the writer is empty.
REQ-019 While out_valid=1 and out_ready=0, out_char and out_valid SHALL stay stable.
REQ-020 Characters SHALL be emitted in acceptance order; no drops or duplicates.
REQ-021 Simultaneous push and pop with FIFO neither full nor empty SHALL keep occupancy unchanged.
REQ-022 char_count SHALL increment by 1 per output transfer and saturate at all-ones.
REQ-023 has_finished SHALL rise the cycle after the final output transfer and hold until reset; in DONE, in_ready=0 and out_valid=0.
REQ-024 in_valid in DONE SHALL be ignored without error.

Reset
REQ-025 With state_enable=0: FSM=IDLE, FIFO flushed, out_char=0, out_valid=0, in_ready=0, has_finished=0, char_count=0, asynchronously and at any point mid-document.
REQ-026 in_ready SHALL rise on the first edge after state_enable returns to 1.

Configuration
REQ-027 Macro HTML_WRITER_CRLF_EN defined: each LF (0x0A) at FIFO head SHALL emit CR (0x0D) first, then LF, as two output transfers, each counted.
REQ-028 Macro HTML_WRITER_CRLF_EN undefined: all characters pass unmodified.

Structure
REQ-029 Shared package html_pkg SHALL hold CHAR_W=8, CHAR_CR, CHAR_LF and the writer state enum.
REQ-030 Storage SHALL be a sub-module char_fifo (DEPTH x 9 bits: char plus last flag, full/empty flags); html_writer holds FSM, output stage, CRLF logic and counter.

Verification
REQ-031 Send "<p>" with last on '>' and out_ready=1 -> out "<p>" in order, char_count=3, has_finished=1 one cycle after '>' is emitted.
REQ-032 out_ready=0, push 16 chars -> in_ready=0 after the 16th; raise out_ready -> all 16 emitted in order, none lost.
REQ-033 Toggle out_ready every cycle while 'A' is stalled -> out_char stays 0x41 until it transfers.
REQ-034 With HTML_WRITER_CRLF_EN, send "a\nb" -> out 0x61,0x0D,0x0A,0x62, char_count=4; without the macro -> 0x61,0x0A,0x62, char_count=3.
REQ-035 Drop state_enable after 5 of 10 chars -> all outputs zero immediately; restart and send "x" with last -> out "x", char_count=1.
REQ-036 CNT_W=4: send 20 chars -> char_count saturates at 15.

Source files
------------

// File: rtl/html_pkg.sv
`default_nettype none
// ============================================================================
// Module   : html_pkg
// Purpose  : Shared character constants and writer state encoding.
// Revision : 1.0
// ============================================================================
package html_pkg;

    localparam int CHAR_W = 8;

    localparam logic [CHAR_W-1:0] CHAR_CR = 8'h0D;
    localparam logic [CHAR_W-1:0] CHAR_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } writer_state_t;

    function automatic logic is_lf(input logic [CHAR_W-1:0] c);
        return (c == CHAR_LF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/char_fifo.sv
`default_nettype none
// ============================================================================
// Module   : char_fifo
// Purpose  : Character FIFO (char + last flag) with registered full/empty.
// Revision : 1.0
// ============================================================================
module char_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int                c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_full_cnt = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic [c_aw:0]    w_count_next;
    logic             r_full;
    logic             r_empty;
    logic             w_push;
    logic             w_pop;

    // Flags are registered, so a full FIFO refuses a push even when popped
    assign w_push = i_push && !r_full;
    assign w_pop  = i_pop && !r_empty;

    always_comb begin
        w_count_next = r_count + (c_aw + 1)'(w_push) - (c_aw + 1)'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_full_cnt);
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule
`default_nettype wire

// File: rtl/html_writer.sv
`default_nettype none
// ============================================================================
// Module   : html_writer
// Purpose  : Buffered character writer with handshakes, completion flag and
//            saturating emitted-character counter. Optional LF -> CR LF
//            expansion when HTML_WRITER_CRLF_EN is defined.
// Revision : 1.0
// ============================================================================
module html_writer
    import html_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic              clock,
    input  logic              state_enable,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    input  logic              in_last,
    output logic              in_ready,
    output logic [7:0]        out_char,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              has_finished,
    output logic [CNT_W-1:0]  char_count
);

    localparam int                  c_held_w   = $clog2(DEPTH) + 1;
    localparam logic [c_held_w-1:0] c_held_max = c_held_w'(DEPTH);

    writer_state_t       r_state;
    writer_state_t       w_state_next;
    logic                r_run;
    logic                r_full;
    logic [c_held_w-1:0] r_held;
    logic [c_held_w-1:0] w_held_next;
    logic [CHAR_W-1:0]   r_out_char;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_out_is_cr;
    logic [CNT_W-1:0]    r_count;

    logic [CHAR_W:0]     w_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_in_xfer;
    logic                w_out_xfer;
    logic                w_load;
    logic                w_emit_cr;
    logic                w_pop;
    logic                w_dec;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_load     = (!r_out_valid || out_ready) && !w_fifo_empty;
    assign w_pop      = w_load && !w_emit_cr;

    char_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_W + 1)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (state_enable),
        .i_push  (w_in_xfer),
        .i_wdata ({in_last, in_char}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

`ifdef HTML_WRITER_CRLF_EN
    logic r_cr_sent;

    // An LF at the head is loaded twice: first as CR (no pop), then as LF
    assign w_emit_cr = w_load && is_lf(w_head[CHAR_W-1:0]) && !r_cr_sent;

    always_ff @(posedge clock or negedge state_enable) begin
        if (!state_enable) begin
            r_cr_sent <= 1'b0;
        end else if (w_load) begin
            r_cr_sent <= w_emit_cr;
        end
    end
`else
    assign w_emit_cr = 1'b0;
`endif

    // Occupancy covers FIFO plus output stage so exactly DEPTH chars fit
    assign w_dec       = w_out_xfer && !r_out_is_cr;
    assign w_held_next = r_held + c_held_w'(w_in_xfer) - c_held_w'(w_dec);

    always_ff @(posedge clock or negedge state_enable) begin
        if (!state_enable) begin
            r_state     <= IDLE;
            r_run       <= 1'b0;
            r_held      <= '0;
            r_full      <= 1'b0;
            r_out_char  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_is_cr <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
            r_held  <= w_held_next;
            r_full  <= (w_held_next == c_held_max);
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_char  <= w_emit_cr ? CHAR_CR : w_head[CHAR_W-1:0];
                r_out_last  <= w_head[CHAR_W] && !w_emit_cr;
                r_out_is_cr <= w_emit_cr;
            end else if (w_out_xfer) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_xfer && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Every char passes through the FIFO, so the final char is always
    // accepted before it can leave: completion is reached only via DRAIN.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_in_xfer) begin
                    w_state_next = in_last ? DRAIN : STREAM;
                end
            end
            STREAM: begin
                if (w_in_xfer && in_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_xfer && r_out_last) begin
                    w_state_next = DONE;
                end
            end
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    assign in_ready     = r_run && !r_full && !w_fifo_full &&
                          ((r_state == IDLE) || (r_state == STREAM));
    assign out_char     = r_out_char;
    assign out_valid    = r_out_valid;
    assign has_finished = (r_state == DONE);
    assign char_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_html_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_html_writer
// Purpose  : Self-checking bench for html_writer against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_html_writer;

    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int SAT_W = 4;

    logic             clock = 1'b0;
    logic             state_enable = 1'b1;
    logic             in_valid = 1'b0;
    logic [7:0]       in_char = 8'h00;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic [7:0]       out_char;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             has_finished;
    logic [CNT_W-1:0] char_count;

    logic             s_in_valid = 1'b0;
    logic [7:0]       s_in_char = 8'h00;
    logic             s_in_last = 1'b0;
    logic             s_in_ready;
    logic [7:0]       s_out_char;
    logic             s_out_valid;
    logic             s_out_ready = 1'b1;
    logic             s_has_finished;
    logic [SAT_W-1:0] s_char_count;

    int n_checks = 0;
    int n_pass   = 0;
    int s_xfers  = 0;

    logic [7:0] sent_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    html_writer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .state_enable (state_enable),
        .in_valid     (in_valid),
        .in_char      (in_char),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_char     (out_char),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .has_finished (has_finished),
        .char_count   (char_count)
    );

    html_writer #(.DEPTH(DEPTH), .CNT_W(SAT_W)) dut_sat (
        .clock        (clock),
        .state_enable (state_enable),
        .in_valid     (s_in_valid),
        .in_char      (s_in_char),
        .in_last      (s_in_last),
        .in_ready     (s_in_ready),
        .out_char     (s_out_char),
        .out_valid    (s_out_valid),
        .out_ready    (s_out_ready),
        .has_finished (s_has_finished),
        .char_count   (s_char_count)
    );

    // Reference: each accepted char appears once, LF gains a leading CR
    function automatic void build_expected();
        exp_q.delete();
        foreach (sent_q[i]) begin
`ifdef HTML_WRITER_CRLF_EN
            if (sent_q[i] == 8'h0A) exp_q.push_back(8'h0D);
`endif
            exp_q.push_back(sent_q[i]);
        end
    endfunction

    function automatic int sat_count(input int n, input int w);
        int max_v;
        max_v = (1 << w) - 1;
        return (n > max_v) ? max_v : n;
    endfunction

    function automatic int first_diff();
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= got_q.size()) return i;
            if (got_q[i] !== exp_q[i]) return i;
        end
        if (got_q.size() > exp_q.size()) return exp_q.size();
        return -1;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clock);
            if (state_enable && out_valid && out_ready) got_q.push_back(out_char);
            if (state_enable && s_out_valid && s_out_ready) s_xfers++;
        end
    endtask

    task automatic send_char(input logic [7:0] c, input logic last);
        bit acc;
        acc = 0;
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (in_ready) begin
                acc = 1;
                break;
            end
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (acc) begin
            sent_q.push_back(c);
        end else begin
            n_checks++;
            $display("FAIL send_timeout: char %h not accepted, in_ready=%b required 1", c, in_ready);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clock);
            if (has_finished) begin
                ok = 1;
                break;
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        in_valid   = 1'b0;
        s_in_valid = 1'b0;
        out_ready  = 1'b0;
        @(posedge clock);
        #1;
        state_enable = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        state_enable = 1'b1;
        sent_q.delete();
        got_q.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        in_valid  = 1'b1;
        in_char   = 8'h55;
        out_ready = 1'b1;
        #2 state_enable = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else n_pass++;
        n_checks++; if (out_char !== 8'h00) $display("FAIL rst_out_char: got %h required 00", out_char); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b required 0", in_ready); else n_pass++;
        n_checks++; if (has_finished !== 1'b0) $display("FAIL rst_finished: got %b required 0", has_finished); else n_pass++;
        n_checks++; if (char_count !== '0) $display("FAIL rst_count: got %0d required 0", char_count); else n_pass++;
        repeat (3) @(posedge clock);
        #1;
        in_valid = 1'b0;
        state_enable = 1'b1;
        @(negedge clock);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rel_in_ready_early: got %b required 0", in_ready); else n_pass++;
        @(posedge clock);
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b required 1", in_ready); else n_pass++;
    endtask

    task automatic test_paragraph();
        bit ok, last_xfer;
        logic [CNT_W-1:0] cnt_done;
        int d;
        reset_dut();
        out_ready = 1'b1;
        send_char(8'h3C, 1'b0);
        send_char(8'h70, 1'b0);
        send_char(8'h3E, 1'b1);
        ok = 0;
        last_xfer = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (has_finished) begin
                ok = 1;
                break;
            end
            last_xfer = out_valid && out_ready;
        end
        #1;
        n_checks++; if (!ok) $display("FAIL para_finish: has_finished=%b required 1", has_finished); else n_pass++;
        n_checks++; if (last_xfer !== 1'b1) $display("FAIL para_finish_timing: transfer on prior cycle=%b required 1", last_xfer); else n_pass++;
        build_expected();
        d = first_diff();
        n_checks++; if (d >= 0) $display("FAIL para_seq: got %0d chars required %0d, first diff at %0d", got_q.size(), exp_q.size(), d); else n_pass++;
        n_checks++; if (char_count !== CNT_W'(3)) $display("FAIL para_count: got %0d required 3", char_count); else n_pass++;
        cnt_done = char_count;
        in_valid = 1'b1;
        in_char  = 8'h7A;
        repeat (3) @(negedge clock);
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL done_idle: in_ready=%b out_valid=%b required 0 0", in_ready, out_valid); else n_pass++;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        n_checks++; if (char_count !== cnt_done || has_finished !== 1'b1) $display("FAIL done_hold: count=%0d finished=%b required %0d 1", char_count, has_finished, cnt_done); else n_pass++;
    endtask

    task automatic test_backpressure();
        int d;
        bit ok;
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_char(8'($urandom_range(32, 126)), 1'b0);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full: in_ready=%b required 0", in_ready); else n_pass++;
        in_valid = 1'b1;
        in_char  = 8'h21;
        repeat (3) @(negedge clock);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_hold_full: in_ready=%b required 0", in_ready); else n_pass++;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        ok = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            #1;
            if (got_q.size() >= DEPTH) begin
                ok = 1;
                break;
            end
        end
        repeat (3) @(negedge clock);
        #1;
        build_expected();
        d = first_diff();
        n_checks++; if (!ok || d >= 0) $display("FAIL bp_seq: got %0d chars required %0d, first diff at %0d", got_q.size(), exp_q.size(), d); else n_pass++;
    endtask

    task automatic test_stall();
        reset_dut();
        out_ready = 1'b0;
        send_char(8'h41, 1'b0);
        @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++; if (out_valid !== 1'b1 || out_char !== 8'h41) $display("FAIL stall_%0d: valid=%b char=%h required 1 41", i, out_valid, out_char); else n_pass++;
        end
        @(posedge clock);
        #1;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        n_checks++; if (got_q.size() != 1 || got_q[0] !== 8'h41) $display("FAIL stall_xfer: got %0d chars required one 41", got_q.size()); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stall_after: out_valid=%b required 0", out_valid); else n_pass++;
    endtask

    task automatic test_crlf();
        bit ok;
        int d;
        reset_dut();
        out_ready = 1'b1;
        send_char(8'h61, 1'b0);
        send_char(8'h0A, 1'b0);
        send_char(8'h62, 1'b1);
        wait_done(60, ok);
        build_expected();
        d = first_diff();
        n_checks++; if (!ok || d >= 0) $display("FAIL crlf_seq: got %0d chars required %0d, first diff at %0d", got_q.size(), exp_q.size(), d); else n_pass++;
        n_checks++; if (char_count !== CNT_W'(exp_q.size())) $display("FAIL crlf_count: got %0d required %0d", char_count, exp_q.size()); else n_pass++;
    endtask

    task automatic test_random();
        int n;
        bit ok, prev_stall;
        logic [7:0] prev_char;
        int d;
        n = 40;
        ok = 0;
        prev_stall = 0;
        prev_char = 8'h00;
        reset_dut();
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    logic [7:0] c;
                    int gap;
                    c = ($urandom_range(0, 7) == 0) ? 8'h0A : 8'($urandom_range(32, 126));
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin
                        repeat (gap) @(posedge clock);
                        #1;
                    end
                    send_char(c, i == n - 1);
                end
            end
            begin
                for (int k = 0; k < 3000; k++) begin
                    @(negedge clock);
                    if (prev_stall) begin
                        n_checks++;
                        if (out_valid !== 1'b1 || out_char !== prev_char) $display("FAIL rnd_stable: valid=%b char=%h required 1 %h", out_valid, out_char, prev_char); else n_pass++;
                    end
                    if (has_finished) begin
                        ok = 1;
                        break;
                    end
                    prev_stall = out_valid && !out_ready;
                    prev_char  = out_char;
                    @(posedge clock);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        #1;
        n_checks++; if (!ok) $display("FAIL rnd_finish: has_finished=%b required 1", has_finished); else n_pass++;
        build_expected();
        d = first_diff();
        n_checks++; if (d >= 0) $display("FAIL rnd_seq: got %0d chars required %0d, first diff at %0d", got_q.size(), exp_q.size(), d); else n_pass++;
        n_checks++; if (char_count !== CNT_W'(sat_count(exp_q.size(), CNT_W))) $display("FAIL rnd_count: got %0d required %0d", char_count, exp_q.size()); else n_pass++;
    endtask

    task automatic test_midreset();
        bit ok;
        int d;
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_char(8'($urandom_range(32, 126)), 1'b0);
        @(posedge clock);
        #3;
        state_enable = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_char !== 8'h00) $display("FAIL mid_out: valid=%b char=%h required 0 00", out_valid, out_char); else n_pass++;
        n_checks++; if (in_ready !== 1'b0 || has_finished !== 1'b0) $display("FAIL mid_flags: in_ready=%b finished=%b required 0 0", in_ready, has_finished); else n_pass++;
        n_checks++; if (char_count !== '0) $display("FAIL mid_count: got %0d required 0", char_count); else n_pass++;
        @(posedge clock);
        #1;
        state_enable = 1'b1;
        sent_q.delete();
        got_q.delete();
        send_char(8'h78, 1'b1);
        wait_done(40, ok);
        build_expected();
        d = first_diff();
        n_checks++; if (!ok || d >= 0) $display("FAIL mid_restart_seq: got %0d chars required %0d, first diff at %0d", got_q.size(), exp_q.size(), d); else n_pass++;
        n_checks++; if (char_count !== CNT_W'(1)) $display("FAIL mid_restart_count: got %0d required 1", char_count); else n_pass++;
    endtask

    task automatic test_saturate();
        int base;
        bit acc, ok;
        reset_dut();
        base = s_xfers;
        for (int i = 0; i < 20; i++) begin
            s_in_valid = 1'b1;
            s_in_char  = 8'($urandom_range(32, 126));
            s_in_last  = (i == 19);
            acc = 0;
            for (int k = 0; k < 100; k++) begin
                @(negedge clock);
                if (s_in_ready) begin
                    acc = 1;
                    break;
                end
            end
            @(posedge clock);
            #1;
            s_in_valid = 1'b0;
            s_in_last  = 1'b0;
            if (!acc) begin
                n_checks++;
                $display("FAIL sat_send_%0d: s_in_ready=%b required 1", i, s_in_ready);
            end
        end
        ok = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (s_has_finished) begin
                ok = 1;
                break;
            end
        end
        #1;
        n_checks++; if (!ok || (s_xfers - base) != 20) $display("FAIL sat_xfers: got %0d transfers required 20", s_xfers - base); else n_pass++;
        n_checks++; if (s_char_count !== SAT_W'(sat_count(20, SAT_W))) $display("FAIL sat_count: got %0d required 15", s_char_count); else n_pass++;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_paragraph();
        test_backpressure();
        test_stall();
        test_crlf();
        test_random();
        test_midreset();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
